// File: rtl/riscv_boot_pkg.sv
// Shared types for the boot loader: FSM states, sticky error codes and the default frame sync byte.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_LEN0  = 3'd2,
    ST_LEN1  = 3'd3,
    ST_DATA  = 3'd4,
    ST_WRITE = 3'd5,
    ST_CSUM  = 3'd6
  } boot_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LEN_OVF = 2'd2,
    ERR_CSUM    = 2'd3
  } boot_err_t;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

endpackage

// File: rtl/boot_timeout_cnt.sv
// Loadable saturating down-counter; expired is high while enabled and the count sits at zero.
// Loading LOAD_VAL at a byte makes expired assert LOAD_VAL+1 cycles later.
module boot_timeout_cnt #(
  parameter int unsigned W        = 24,
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload)
      cnt_d = LOAD;
    else if (enable && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= LOAD;
    else         cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/riscv_boot_loader.sv
// Boot sequencer: receives a framed image from UART RX, writes it into RAM word by word,
// validates the checksum and releases the CPU. All outputs registered, one cycle after the causing byte.
module riscv_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned RAM_DEPTH  = 8192,
  parameter int unsigned WL         = 32,
  parameter logic [7:0]  MAGIC      = BOOT_MAGIC,
  parameter int unsigned TIMEOUT_MS = 100,
  localparam int unsigned AW        = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [WL-1:0] ram_wdata,
  output logic          ram_own,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic [1:0]    error
);

  localparam int unsigned TO_CYC  = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned TO_LOAD = (TO_CYC >= 2) ? TO_CYC - 2 : 0;
  localparam int unsigned TO_W    = (TO_LOAD < 2) ? 1 : $clog2(TO_LOAD + 1);

  boot_state_t   state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   buf_q, buf_d;
  logic [7:0]    csum_q, csum_d;

  logic [3:0]    ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [WL-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_own_q, ram_own_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  boot_err_t     error_q, error_d;

  logic          ev_start, ev_ok, ev_err, ev_wr;
  boot_err_t     err_code;
  logic [15:0]   len_full;
  logic          tmo_reload, tmo_enable, tmo_expired;

  assign tmo_enable = (state_q != ST_IDLE);

  generate
    if (TIMEOUT_MS != 0) begin : g_tmo
      boot_timeout_cnt #(
        .W        (TO_W),
        .LOAD_VAL (TO_LOAD)
      ) u_tmo (
        .clk     (clk),
        .resetn  (resetn),
        .reload  (tmo_reload),
        .enable  (tmo_enable),
        .expired (tmo_expired)
      );
    end else begin : g_no_tmo
      assign tmo_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wcnt_q      <= '0;
      bidx_q      <= '0;
      buf_q       <= '0;
      csum_q      <= '0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_own_q   <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      bidx_q      <= bidx_d;
      buf_q       <= buf_d;
      csum_q      <= csum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_own_q   <= ram_own_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    bidx_d     = bidx_q;
    buf_d      = buf_q;
    csum_d     = csum_q;
    ev_start   = 1'b0;
    ev_ok      = 1'b0;
    ev_err     = 1'b0;
    ev_wr      = 1'b0;
    err_code   = ERR_NONE;
    tmo_reload = (state_q != ST_IDLE) && rx_valid;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ev_start   = 1'b1;
          tmo_reload = 1'b1;
          state_d    = ST_SYNC;
          len_d      = '0;
          wcnt_d     = '0;
          bidx_d     = '0;
          csum_d     = '0;
        end
      end
      ST_SYNC: begin
        if (rx_valid && (rx_data == MAGIC)) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          csum_d     = csum_q + rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_valid) begin
          len_d  = len_full;
          csum_d = csum_q + rx_data;
          if (32'(len_full) > RAM_DEPTH) begin
            ev_err   = 1'b1;
            err_code = ERR_LEN_OVF;
            state_d  = ST_IDLE;
          end else if (len_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q + rx_data;
          if (bidx_q == 2'd3) begin
            ev_wr   = 1'b1;
            bidx_d  = '0;
            state_d = ST_WRITE;
          end else begin
            case (bidx_q)
              2'd0:    buf_d[7:0]   = rx_data;
              2'd1:    buf_d[15:8]  = rx_data;
              default: buf_d[23:16] = rx_data;
            endcase
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      ST_WRITE: begin
        wcnt_d = wcnt_q + 16'd1;
        // A byte landing here is either byte 0 of the next word or, after the last word, the checksum.
        if (wcnt_d == len_q) begin
          if (rx_valid) begin
            ev_ok    = (rx_data == csum_q);
            ev_err   = (rx_data != csum_q);
            err_code = ERR_CSUM;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_CSUM;
          end
        end else begin
          state_d = ST_DATA;
          if (rx_valid) begin
            buf_d[7:0] = rx_data;
            bidx_d     = 2'd1;
            csum_d     = csum_q + rx_data;
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          ev_ok    = (rx_data == csum_q);
          ev_err   = (rx_data != csum_q);
          err_code = ERR_CSUM;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !rx_valid && tmo_expired) begin
      ev_err   = 1'b1;
      err_code = ERR_TIMEOUT;
      state_d  = ST_IDLE;
    end
  end

  always_comb begin
    ram_we_d    = ev_wr ? 4'hF : 4'h0;
    ram_addr_d  = ev_wr ? wcnt_q[AW-1:0] : ram_addr_q;
    ram_wdata_d = ev_wr ? {rx_data, buf_q} : ram_wdata_q;
    cpu_reset_d = cpu_reset_q;
    ram_own_d   = ram_own_q;
    error_d     = error_q;
    if (ev_start) begin
      cpu_reset_d = 1'b1;
      ram_own_d   = 1'b1;
      error_d     = ERR_NONE;
    end
    if (ev_ok) begin
      cpu_reset_d = 1'b0;
      ram_own_d   = 1'b0;
    end
    if (ev_err) begin
      ram_own_d = 1'b0;
      error_d   = err_code;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = ev_ok;
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_own   = ram_own_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
